// File: rtl/ro_pair_compare_if.sv
// Handshake and result bundle between the RO pair comparator and its requester.
interface ro_pair_compare_if #(
   parameter int SEL_W = 4,
   parameter int CNT_W = 16
) ();
   logic               Start;
   logic [2*SEL_W-1:0] Challenge;
   logic               Busy;
   logic               Done;
   logic               Response;
   logic               Tie;
   logic               Error;
   logic [CNT_W-1:0]   CountA;
   logic [CNT_W-1:0]   CountB;

   modport master (
      output Start, Challenge,
      input  Busy, Done, Response, Tie, Error, CountA, CountB
   );

   modport slave (
      input  Start, Challenge,
      output Busy, Done, Response, Tie, Error, CountA, CountB
   );
endinterface

// File: rtl/ro_pair_compare.sv
// Ring-oscillator pair comparator: selects two ROs by challenge, counts rising
// edges over a fixed window and reports which one is faster as a PUF bit.
module ro_pair_compare #(
   parameter int N_RO   = 16,
   parameter int SEL_W  = 4,
   parameter int CNT_W  = 16,
   parameter int WINDOW = 1024,
   parameter int SETTLE = 3
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [N_RO-1:0] RO_In,
   ro_pair_compare_if.slave bus
);

   localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_COUNT,
      S_COMPARE
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic [TW-1:0]      tmr_q, tmr_d;
   logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [CNT_W-1:0]   cnt_a_n, cnt_b_n;
   logic               busy_q, busy_d, done_q, done_d;
   logic               resp_q, resp_d, tie_q, tie_d, err_q, err_d;
   logic [2:0]         sync_a_q, sync_b_q;
   logic [(1<<SEL_W)-1:0] ro_pad;
   logic [SEL_W-1:0]   ch_a, ch_b;
   logic               ch_bad, rise_a, rise_b;

   // Pad to the full select range so a latched out-of-range select reads 0.
   always_comb begin
      ro_pad = '0;
      ro_pad[N_RO-1:0] = RO_In;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync_a_q <= '0;
         sync_b_q <= '0;
      end else begin
         sync_a_q <= {sync_a_q[1:0], ro_pad[sel_a_q]};
         sync_b_q <= {sync_b_q[1:0], ro_pad[sel_b_q]};
      end
   end

   assign rise_a = sync_a_q[1] & ~sync_a_q[2];
   assign rise_b = sync_b_q[1] & ~sync_b_q[2];

   assign ch_a   = bus.Challenge[2*SEL_W-1:SEL_W];
   assign ch_b   = bus.Challenge[SEL_W-1:0];
   assign ch_bad = (ch_a == ch_b) || (int'(ch_a) >= N_RO) || (int'(ch_b) >= N_RO);

   assign cnt_a_n = (rise_a && (cnt_a_q != '1)) ? cnt_a_q + 1'b1 : cnt_a_q;
   assign cnt_b_n = (rise_b && (cnt_b_q != '1)) ? cnt_b_q + 1'b1 : cnt_b_q;

   always_comb begin
      state_d = state_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      tmr_d   = tmr_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      resp_d  = resp_q;
      tie_d   = tie_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            // done_q blocks acceptance in the Done cycle of a rejected challenge
            if (bus.Start && !done_q) begin
               sel_a_d = ch_a;
               sel_b_d = ch_b;
               tmr_d   = '0;
               cnt_a_d = '0;
               cnt_b_d = '0;
               resp_d  = 1'b0;
               tie_d   = 1'b0;
               err_d   = 1'b0;
               if (ch_bad) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (tmr_q == TW'(SETTLE - 1)) begin
               tmr_d   = '0;
               state_d = S_COUNT;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_COUNT: begin
            cnt_a_d = cnt_a_n;
            cnt_b_d = cnt_b_n;
            // Result is registered from the final counts on entry to COMPARE,
            // so the COMPARE cycle itself is the Done cycle.
            if (tmr_q == TW'(WINDOW - 1)) begin
               resp_d  = (cnt_a_n > cnt_b_n);
               tie_d   = (cnt_a_n == cnt_b_n);
               err_d   = 1'b0;
               done_d  = 1'b1;
               state_d = S_COMPARE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_COMPARE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         sel_a_q <= '0;
         sel_b_q <= '0;
         tmr_q   <= '0;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         resp_q  <= 1'b0;
         tie_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         tmr_q   <= tmr_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         resp_q  <= resp_d;
         tie_q   <= tie_d;
         err_q   <= err_d;
      end
   end

   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;
   assign bus.Response = resp_q;
   assign bus.Tie      = tie_q;
   assign bus.Error    = err_q;
   assign bus.CountA   = cnt_a_q;
   assign bus.CountB   = cnt_b_q;

endmodule

// File: tb/tb_ro_pair_compare.sv
// Bench for ro_pair_compare: two configurations (full 16-RO/16-bit and
// 12-RO/4-bit) driven by directed steps, results checked via a scoreboard.
module tb_ro_pair_compare;

   typedef struct {
      int done_cyc;
      int alo, ahi, blo, bhi;
      bit resp, tie, err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [15:0] ro;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          nd0 = 0;
   int          nd1 = 0;
   exp_t        q0[$];
   exp_t        q1[$];

   ro_pair_compare_if #(.SEL_W(4), .CNT_W(16)) bus0 ();
   ro_pair_compare_if #(.SEL_W(4), .CNT_W(4))  bus1 ();

   ro_pair_compare #(.N_RO(16), .SEL_W(4), .CNT_W(16), .WINDOW(100), .SETTLE(3)) dut0 (
      .Clock(clk), .Reset(rst), .RO_In(ro), .bus(bus0)
   );

   ro_pair_compare #(.N_RO(12), .SEL_W(4), .CNT_W(4), .WINDOW(100), .SETTLE(3)) dut1 (
      .Clock(clk), .Reset(rst), .RO_In(ro[11:0]), .bus(bus1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Free-running oscillators, updated away from the sampling edge.
   always @(negedge clk) begin
      ro    = '0;
      ro[3] = (cyc % 4) < 2;
      ro[4] = (cyc % 6) < 3;
      ro[5] = (cyc % 8) < 4;
      ro[7] = (cyc % 10) < 5;
      ro[9] = (cyc % 8) < 4;
      ro[1] = (cyc % 6) < 3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic check_done(input int d, input logic r, input logic t, input logic e,
                             input logic [31:0] ca, input logic [31:0] cb);
      exp_t x;
      int   sz;
      sz = (d == 0) ? q0.size() : q1.size();
      checks++;
      assert (sz > 0) else begin
         failures++;
         $error("FAIL unexpected_done dut=%0d observed=%0d expected=1", d, sz);
      end
      if (sz > 0) begin
         x = (d == 0) ? q0.pop_front() : q1.pop_front();
         chk("done_cycle", cyc, x.done_cyc);
         chk("response", r, x.resp);
         chk("tie", t, x.tie);
         chk("error", e, x.err);
         chk_rng("count_a", ca, x.alo, x.ahi);
         chk_rng("count_b", cb, x.blo, x.bhi);
      end
   endtask

   always @(negedge clk) begin
      if (bus0.Done === 1'b1) begin
         nd0++;
         check_done(0, bus0.Response, bus0.Tie, bus0.Error, bus0.CountA, bus0.CountB);
      end
      if (bus1.Done === 1'b1) begin
         nd1++;
         check_done(1, bus1.Response, bus1.Tie, bus1.Error, bus1.CountA, bus1.CountB);
      end
   end

   function automatic void push(input int d, input int dc, input int alo, input int ahi,
                                input int blo, input int bhi, input bit r, input bit t, input bit e);
      exp_t x;
      x.done_cyc = dc;
      x.alo = alo; x.ahi = ahi; x.blo = blo; x.bhi = bhi;
      x.resp = r; x.tie = t; x.err = e;
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
   endfunction

   // Returns s = cycle index in which Start was sampled (Done cycles are s+1 / s+104).
   task automatic launch(input int d, input int a, input int b, output int s);
      @(negedge clk);
      if (d == 0) begin
         bus0.Start = 1'b1; bus0.Challenge = {4'(a), 4'(b)};
      end else begin
         bus1.Start = 1'b1; bus1.Challenge = {4'(a), 4'(b)};
      end
      @(posedge clk);
      #1;
      s = cyc - 1;
      bus0.Start = 1'b0;
      bus1.Start = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_timeout", q0.size() + q1.size(), 0);
   endtask

   initial begin
      int s;
      int n0;
      rst = 1'b1;
      bus0.Start = 1'b0; bus0.Challenge = '0;
      bus1.Start = 1'b0; bus1.Challenge = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_busy", bus0.Busy, 0);
      chk("rst_done", bus0.Done, 0);
      chk("rst_resp", bus0.Response, 0);
      chk("rst_tie", bus0.Tie, 0);
      chk("rst_err", bus0.Error, 0);
      chk("rst_cnta", bus0.CountA, 0);
      chk("rst_cntb", bus0.CountB, 0);
      chk("rst_busy1", bus1.Busy, 0);
      repeat (50) @(posedge clk);
      #1 chk("idle_no_done", nd0 + nd1, 0);

      // Basic, swapped and tie on the 16-bit instance
      launch(0, 3, 7, s);
      push(0, s + 104, 24, 26, 9, 11, 1, 0, 0);
      #1 chk("busy_after_start", bus0.Busy, 1);
      wait_drain();
      chk("busy_after_done", bus0.Busy, 0);
      launch(0, 7, 3, s);
      push(0, s + 104, 9, 11, 24, 26, 0, 0, 0);
      wait_drain();
      launch(0, 5, 9, s);
      push(0, s + 104, 12, 13, 12, 13, 0, 1, 0);
      wait_drain();

      // Rejected challenges
      launch(0, 4, 4, s);
      push(0, s + 1, 0, 0, 0, 0, 0, 0, 1);
      wait_drain();
      launch(1, 13, 1, s);
      push(1, s + 1, 0, 0, 0, 0, 0, 0, 1);
      wait_drain();

      // Saturation, with an ignored Start/Challenge change mid-window
      launch(1, 3, 7, s);
      push(1, s + 104, 15, 15, 9, 11, 1, 0, 0);
      repeat (60) @(posedge clk);
      #1 bus1.Start = 1'b1; bus1.Challenge = {4'd5, 4'd9};
      @(posedge clk);
      #1 bus1.Start = 1'b0;
      wait_drain();

      // Start held high: next accepted in the first IDLE cycle after Done
      @(negedge clk);
      bus0.Start = 1'b1; bus0.Challenge = {4'd3, 4'd7};
      @(posedge clk);
      #1 s = cyc - 1;
      push(0, s + 104, 24, 26, 9, 11, 1, 0, 0);
      push(0, s + 209, 24, 26, 9, 11, 1, 0, 0);
      repeat (105) @(posedge clk);
      #1 bus0.Start = 1'b0;
      wait_drain();

      // Reset mid-window aborts; Reset beats a simultaneous Start
      n0 = nd0;
      launch(0, 3, 7, s);
      repeat (52) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_busy", bus0.Busy, 0);
      chk("abort_cnta", bus0.CountA, 0);
      @(negedge clk);
      rst = 1'b1; bus0.Start = 1'b1; bus0.Challenge = {4'd3, 4'd7};
      @(posedge clk);
      #1 rst = 1'b0; bus0.Start = 1'b0;
      chk("rst_start_busy", bus0.Busy, 0);
      repeat (150) @(posedge clk);
      #1 chk("abort_no_done", nd0, n0);

      launch(0, 3, 7, s);
      push(0, s + 104, 24, 26, 9, 11, 1, 0, 0);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
